// File: rtl/dir_queue.sv
// Direction command queue: edge-detects held key codes, filters null/reversal turns,
// buffers accepted turns and releases one per unpaused game step with a move strobe.
module dir_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input  logic             clk_25M,
  input  logic             rst,
  input  logic [2:0]       key_stroke,
  input  logic             step,
  output logic [1:0]       cur_dir,
  output logic             move,
  output logic             paused,
  output logic [PTR_W:0]   q_count,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [2:0] {
    KEY_NONE  = 3'b000,
    KEY_UP    = 3'b001,
    KEY_DOWN  = 3'b010,
    KEY_LEFT  = 3'b011,
    KEY_RIGHT = 3'b100,
    KEY_PAUSE = 3'b101
  } key_e;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [2:0]       key_prev_q, key_prev_d;
  logic             step_prev_q, step_prev_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic             move_q, move_d;
  logic             paused_q, paused_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];

  logic             key_evt, dir_evt, pause_evt, tick;
  logic [1:0]       evt_dir, ref_dir, opp_dir;
  logic [PTR_W-1:0] last_ptr;
  logic             accept, full, push, pop, drop;

  always_comb begin
    key_evt   = (key_stroke != key_prev_q) && (key_stroke != KEY_NONE);
    dir_evt   = key_evt && (key_stroke >= KEY_UP) && (key_stroke <= KEY_RIGHT);
    pause_evt = key_evt && (key_stroke == KEY_PAUSE);
    // codes 001..100 map to 00..11 by subtracting one from the low two bits
    evt_dir   = key_stroke[1:0] - 2'd1;
    tick      = step & ~step_prev_q;

    last_ptr  = wr_ptr_q - PTR_W'(1);
    ref_dir   = (count_q != '0) ? mem_q[last_ptr] : cur_dir_q;
    opp_dir   = {ref_dir[1], ~ref_dir[0]};
    accept    = dir_evt && (evt_dir != ref_dir) && (evt_dir != opp_dir);
    full      = (count_q == DEPTH_C);
    pop       = tick && !paused_q && (count_q != '0);
    // a pop in the same cycle frees a slot, so a full queue can still accept
    push      = accept && (!full || pop);
    drop      = accept && full && !pop;
  end

  always_comb begin
    key_prev_d  = key_stroke;
    step_prev_d = step;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cur_dir_d   = cur_dir_q;
    move_d      = tick && !paused_q;
    paused_d    = paused_q ^ pause_evt;
    drop_cnt_d  = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = evt_dir;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      cur_dir_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      key_prev_q  <= '0;
      step_prev_q <= 1'b0;
      cur_dir_q   <= INIT_DIR;
      move_q      <= 1'b0;
      paused_q    <= 1'b0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      key_prev_q  <= key_prev_d;
      step_prev_q <= step_prev_d;
      cur_dir_q   <= cur_dir_d;
      move_q      <= move_d;
      paused_q    <= paused_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage is only read behind count_q, so it needs no reset.
  always_ff @(posedge clk_25M) begin
    mem_q <= mem_d;
  end

  assign cur_dir  = cur_dir_q;
  assign move     = move_q;
  assign paused   = paused_q;
  assign q_count  = count_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_dir_queue.sv
// Bench for dir_queue: directed scenarios plus random keys/steps, checked every cycle
// against a queue-based behavioural model.
module tb_dir_queue;

  localparam int DEPTH = 4;

  logic       clk_25M = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_stroke = 3'b000;
  logic       step = 1'b0;
  logic [1:0] cur_dir;
  logic       move;
  logic       paused;
  logic [2:0] q_count;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  int mv_seen = 0;

  dir_queue #(.DEPTH(4), .PTR_W(2), .INIT_DIR(2'b11)) dut (
    .clk_25M    (clk_25M),
    .rst        (rst),
    .key_stroke (key_stroke),
    .step       (step),
    .cur_dir    (cur_dir),
    .move       (move),
    .paused     (paused),
    .q_count    (q_count),
    .drop_cnt   (drop_cnt)
  );

  always #20 clk_25M = ~clk_25M;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_q[$];
  int m_cur = 3;
  int m_move = 0;
  int m_paused = 0;
  int m_drop = 0;
  int m_prev_key = 0;
  int m_prev_step = 0;

  always @(posedge clk_25M) begin
    int k, s, evt, tk, ref_d, d, sz, popping;
    k = int'(key_stroke);
    s = int'(step);
    if (rst) begin
      m_q.delete();
      m_cur = 3; m_move = 0; m_paused = 0; m_drop = 0;
      m_prev_key = 0; m_prev_step = 0;
    end else begin
      evt     = (k != m_prev_key && k != 0) ? 1 : 0;
      tk      = (s == 1 && m_prev_step == 0) ? 1 : 0;
      sz      = m_q.size();
      ref_d   = (sz > 0) ? m_q[$] : m_cur;
      popping = (tk == 1 && m_paused == 0 && sz > 0) ? 1 : 0;
      m_move  = (tk == 1 && m_paused == 0) ? 1 : 0;
      if (popping == 1) m_cur = m_q.pop_front();
      if (evt == 1 && k >= 1 && k <= 4) begin
        d = k - 1;
        if (d != ref_d && d != (ref_d ^ 1)) begin
          if (sz < DEPTH || popping == 1) m_q.push_back(d);
          else if (m_drop < 255) m_drop++;
        end
      end
      if (evt == 1 && k == 5) m_paused = 1 - m_paused;
      m_prev_key  = k;
      m_prev_step = s;
    end
    #1;
    chk("cur_dir", int'(cur_dir), m_cur);
    chk("move", int'(move), m_move);
    chk("paused", int'(paused), m_paused);
    chk("q_count", int'(q_count), m_q.size());
    chk("drop_cnt", int'(drop_cnt), m_drop);
    if (move) mv_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_25M);
  endtask

  task automatic press(input logic [2:0] c);
    key_stroke = c;
    cyc(1);
    key_stroke = 3'b000;
    cyc(1);
  endtask

  task automatic tick_step();
    step = 1'b1;
    cyc(2);
    step = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_stroke = 3'b000;
    step = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    int mv0;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // 1: reset state, then three idle ticks
    chk("t1_rst_cur", int'(cur_dir), 3);
    chk("t1_rst_move", int'(move), 0);
    chk("t1_rst_paused", int'(paused), 0);
    chk("t1_rst_q", int'(q_count), 0);
    chk("t1_rst_drop", int'(drop_cnt), 0);
    mv0 = mv_seen;
    repeat (3) tick_step();
    chk("t1_moves", mv_seen - mv0, 3);
    chk("t1_cur", int'(cur_dir), 3);
    chk("t1_q", int'(q_count), 0);

    // 2: two turns buffered within one step period
    press(3'b001);
    press(3'b011);
    chk("t2_q", int'(q_count), 2);
    tick_step();
    chk("t2_tick1_cur", int'(cur_dir), 0);
    tick_step();
    chk("t2_tick2_cur", int'(cur_dir), 2);

    // 3: reversal and null rejection
    do_reset();
    press(3'b011);
    press(3'b100);
    chk("t3_rej_q", int'(q_count), 0);
    press(3'b001);
    press(3'b010);
    chk("t3_q", int'(q_count), 1);

    // 4: overflow, then push+pop on a full queue
    do_reset();
    press(3'b001); press(3'b100); press(3'b001); press(3'b100); press(3'b001);
    chk("t4_full_q", int'(q_count), 4);
    chk("t4_drop", int'(drop_cnt), 1);
    step = 1'b1;
    key_stroke = 3'b001;
    cyc(1);
    key_stroke = 3'b000;
    cyc(1);
    step = 1'b0;
    cyc(2);
    chk("t4_pp_q", int'(q_count), 4);
    chk("t4_pp_drop", int'(drop_cnt), 1);
    chk("t4_pp_cur", int'(cur_dir), 0);

    // 5: pause swallows ticks, keys still accepted
    do_reset();
    press(3'b101);
    chk("t5_paused", int'(paused), 1);
    mv0 = mv_seen;
    tick_step(); tick_step();
    chk("t5_no_move", mv_seen - mv0, 0);
    chk("t5_cur_held", int'(cur_dir), 3);
    press(3'b001);
    chk("t5_q", int'(q_count), 1);
    press(3'b101);
    mv0 = mv_seen;
    tick_step();
    chk("t5_move", mv_seen - mv0, 1);
    chk("t5_cur", int'(cur_dir), 0);

    // 6: held key is one event; reset discards queue
    do_reset();
    key_stroke = 3'b001;
    cyc(50);
    step = 1'b1;
    cyc(50);
    step = 1'b0;
    key_stroke = 3'b000;
    cyc(2);
    chk("t6_held_cur", int'(cur_dir), 0);
    chk("t6_held_q", int'(q_count), 0);
    press(3'b101);
    press(3'b011); press(3'b001); press(3'b100);
    chk("t6_q3", int'(q_count), 3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_rst_q", int'(q_count), 0);
    chk("t6_rst_cur", int'(cur_dir), 3);
    chk("t6_rst_paused", int'(paused), 0);
    cyc(1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) >= 40) key_stroke = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) step = ~step;
      rst = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    rst = 1'b0;

    // drop counter saturation
    do_reset();
    press(3'b001); press(3'b100); press(3'b001); press(3'b100);
    for (int i = 0; i < 130; i++) begin
      press(3'b001);
      press(3'b010);
    end
    chk("sat_drop", int'(drop_cnt), 255);
    chk("sat_q", int'(q_count), 4);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
